// File: rtl/multi_operand_add_seq_if.sv
// rtl/multi_operand_add_seq_if.sv - operand/sum handshake bundle for multi_operand_add_seq
// RUNTIME_COUNT_EN adds the num_ops field.
interface multi_operand_add_seq_if #(
    parameter int WIDTH = 8,
    parameter int N_OPS = 4
);
    localparam int SUM_W = WIDTH + $clog2(N_OPS);
    localparam int CNT_W = $clog2(N_OPS) + 1;

    logic             start;
    logic             op_valid;
    logic [WIDTH-1:0] op_data;
    logic             op_ready;
    logic             busy;
    logic             sum_valid;
    logic             sum_ready;
    logic [SUM_W-1:0] sum;
`ifdef RUNTIME_COUNT_EN
    logic [CNT_W-1:0] num_ops;

    modport master (
        output start, op_valid, op_data, sum_ready, num_ops,
        input  op_ready, busy, sum_valid, sum
    );
    modport slave (
        input  start, op_valid, op_data, sum_ready, num_ops,
        output op_ready, busy, sum_valid, sum
    );
`else
    modport master (
        output start, op_valid, op_data, sum_ready,
        input  op_ready, busy, sum_valid, sum
    );
    modport slave (
        input  start, op_valid, op_data, sum_ready,
        output op_ready, busy, sum_valid, sum
    );
`endif
endinterface

// File: rtl/multi_operand_add_seq.sv
// rtl/multi_operand_add_seq.sv - serial multi-operand adder sequencer sharing one adder
// RUNTIME_COUNT_EN enables a per-sum operand count taken from num_ops at start.
module multi_operand_add_seq #(
    parameter int WIDTH = 8,
    parameter int N_OPS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    multi_operand_add_seq_if.slave bus
);
    localparam int SUM_W = WIDTH + $clog2(N_OPS);
    localparam int CNT_W = $clog2(N_OPS) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(N_OPS);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic [SUM_W-1:0] acc;
    logic [SUM_W-1:0] acc_sum;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             last_op;
    logic             start_empty;

`ifdef RUNTIME_COUNT_EN
    logic [CNT_W-1:0] count_in;

    assign count_in    = (bus.num_ops > MAX_CNT) ? MAX_CNT : bus.num_ops;
    assign start_empty = (bus.num_ops == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (state == IDLE && bus.start) begin
            count <= count_in;
        end
    end
`else
    assign count       = MAX_CNT;
    assign start_empty = 1'b0;
`endif

    assign accept  = bus.op_valid && (state == ACCUM);
    assign last_op = (cnt == count - CNT_W'(1));
    assign acc_sum = acc + {{(SUM_W-WIDTH){1'b0}}, bus.op_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        bus.op_ready  = 1'b0;
        bus.busy      = 1'b0;
        bus.sum_valid = 1'b0;
        bus.sum       = '0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = start_empty ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                bus.op_ready = 1'b1;
                bus.busy     = 1'b1;
                if (accept && last_op) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.sum_valid = 1'b1;
                bus.sum       = acc;
                if (bus.sum_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // The accumulator is only exposed in DONE, so partial sums never reach sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (state == IDLE && bus.start) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc <= acc_sum;
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule
